riscv_instr_encoder: RTL and testbench

Sequential RISC-V RV32I instruction encoder and program loader: accepts an instruction ID plus register and immediate fields over a valid/ready handshake and emits the packed 32-bit instruction word with its target instruction-memory address. It is the inverse of the pipeline's decode/control stage. The bench uses it to build programs, and the instruction-memory preload path writes its output words directly.

---
 rtl/riscv_pkg.sv | 88 ++++++++
 rtl/riscv_instr_encoder_if.sv | 33 +++
 rtl/riscv_encode_fields.sv | 100 ++++++++++
 rtl/riscv_instr_encoder.sv | 134 +++++++++++++
 tb/tb_riscv_instr_encoder.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I instruction encoder:
//   - instr_id_e   : instruction-ID enumeration (IDs 38..63 are illegal)
//   - OP_*         : major opcode constants
//   - F7_BASE/ALT  : funct7 values
//   - f3_of/f7_of  : per-ID funct3 / funct7 lookup
//   - fits_s12/13/21 : signed-range helpers for immediate checking
//   - enc_state_e  : load-session FSM states
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [5:0] {
        ID_NOP   = 6'd0,  ID_ADD  = 6'd1,  ID_SUB   = 6'd2,  ID_SLL   = 6'd3,
        ID_SLT   = 6'd4,  ID_SLTU = 6'd5,  ID_XOR   = 6'd6,  ID_SRL   = 6'd7,
        ID_SRA   = 6'd8,  ID_OR   = 6'd9,  ID_AND   = 6'd10, ID_ADDI  = 6'd11,
        ID_XORI  = 6'd12, ID_ORI  = 6'd13, ID_ANDI  = 6'd14, ID_SLLI  = 6'd15,
        ID_SRLI  = 6'd16, ID_SRAI = 6'd17, ID_SLTI  = 6'd18, ID_SLTIU = 6'd19,
        ID_LB    = 6'd20, ID_LH   = 6'd21, ID_LW    = 6'd22, ID_LBU   = 6'd23,
        ID_LHU   = 6'd24, ID_SB   = 6'd25, ID_SH    = 6'd26, ID_SW    = 6'd27,
        ID_BEQ   = 6'd28, ID_BNE  = 6'd29, ID_BLT   = 6'd30, ID_BGE   = 6'd31,
        ID_BLTU  = 6'd32, ID_BGEU = 6'd33, ID_JAL   = 6'd34, ID_LUI   = 6'd35,
        ID_AUIPC = 6'd36, ID_JALR = 6'd37
    } instr_id_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

    // funct3 per instruction ID; IDs without a funct3 field return 0.
    function automatic logic [2:0] f3_of(input logic [5:0] id);
        logic [2:0] f3;
        case (id)
            ID_ADD, ID_SUB, ID_ADDI, ID_LB, ID_SB, ID_BEQ, ID_JALR: f3 = 3'b000;
            ID_SLL, ID_SLLI, ID_LH, ID_SH, ID_BNE:                  f3 = 3'b001;
            ID_SLT, ID_SLTI, ID_LW, ID_SW:                         f3 = 3'b010;
            ID_SLTU, ID_SLTIU:                                     f3 = 3'b011;
            ID_XOR, ID_XORI, ID_LBU, ID_BLT:                       f3 = 3'b100;
            ID_SRL, ID_SRA, ID_SRLI, ID_SRAI, ID_LHU, ID_BGE:      f3 = 3'b101;
            ID_OR, ID_ORI, ID_BLTU:                                f3 = 3'b110;
            ID_AND, ID_ANDI, ID_BGEU:                              f3 = 3'b111;
            default:                                               f3 = 3'b000;
        endcase
        return f3;
    endfunction

    // funct7: only the arithmetic-variant ops set bit 5.
    function automatic logic [6:0] f7_of(input logic [5:0] id);
        logic [6:0] f7;
        case (id)
            ID_SUB, ID_SRA, ID_SRAI: f7 = F7_ALT;
            default:                 f7 = F7_BASE;
        endcase
        return f7;
    endfunction

    // True when v, read as signed, fits in 12 bits.
    function automatic logic fits_s12(input logic [31:0] v);
        return (v[31:11] == 21'h000000) || (v[31:11] == 21'h1FFFFF);
    endfunction

    // True when v, read as signed, fits in 13 bits.
    function automatic logic fits_s13(input logic [31:0] v);
        return (v[31:12] == 20'h00000) || (v[31:12] == 20'hFFFFF);
    endfunction

    // True when v, read as signed, fits in 21 bits.
    function automatic logic fits_s21(input logic [31:0] v);
        return (v[31:20] == 12'h000) || (v[31:20] == 12'hFFF);
    endfunction

endpackage

// File: rtl/riscv_instr_encoder_if.sv
// -----------------------------------------------------------------------------
// riscv_instr_encoder_if
// Input and output handshakes of the instruction encoder.
//   in_valid/in_ready + in_id/in_rd/in_rs1/in_rs2/in_imm : field input
//   out_valid/out_ready + out_instr/out_addr/out_err     : encoded word output
// Modports: master = program builder, slave = encoder.
// -----------------------------------------------------------------------------
interface riscv_instr_encoder_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_id;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, in_id, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_id, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/riscv_encode_fields.sv
// -----------------------------------------------------------------------------
// riscv_encode_fields
// Purely combinational RV32I encoder: instruction ID + register/immediate
// fields -> packed 32-bit word and error flag.
// Ports:
//   id_i     [5:0]  instruction ID (riscv_pkg::instr_id_e value)
//   rd_i/rs1_i/rs2_i [4:0] register indices
//   imm_i    [31:0] immediate (byte offset for B/J, full value for U)
//   instr_o  [31:0] encoded instruction (0 for illegal IDs)
//   err_o           illegal ID, plus immediate range violations when
//                   ENC_IMM_CHECK_EN is defined
// -----------------------------------------------------------------------------
module riscv_encode_fields
    import riscv_pkg::*;
(
    input  logic [5:0]  id_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [31:0] instr_s;
    logic        illegal_s;

    assign f3_s = f3_of(id_i);
    assign f7_s = f7_of(id_i);

    // Format selection and bit packing; unused fields simply do not appear.
    always_comb begin
        instr_s   = 32'h0000_0000;
        illegal_s = 1'b0;
        case (id_i)
            ID_NOP: instr_s = 32'h0000_0000;
            ID_ADD, ID_SUB, ID_SLL, ID_SLT, ID_SLTU,
            ID_XOR, ID_SRL, ID_SRA, ID_OR, ID_AND:
                instr_s = {f7_s, rs2_i, rs1_i, f3_s, rd_i, OP_R};
            ID_ADDI, ID_XORI, ID_ORI, ID_ANDI, ID_SLTI, ID_SLTIU:
                instr_s = {imm_i[11:0], rs1_i, f3_s, rd_i, OP_IMM};
            // Shift amount sits where rs2 would be; upper bits carry funct7.
            ID_SLLI, ID_SRLI, ID_SRAI:
                instr_s = {f7_s, imm_i[4:0], rs1_i, f3_s, rd_i, OP_IMM};
            ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU:
                instr_s = {imm_i[11:0], rs1_i, f3_s, rd_i, OP_LOAD};
            ID_JALR:
                instr_s = {imm_i[11:0], rs1_i, f3_s, rd_i, OP_JALR};
            ID_SB, ID_SH, ID_SW:
                instr_s = {imm_i[11:5], rs2_i, rs1_i, f3_s, imm_i[4:0], OP_STORE};
            // Branch offsets are halfword granular: bit 0 is never encoded.
            ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU:
                instr_s = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_s,
                           imm_i[4:1], imm_i[11], OP_BRANCH};
            ID_JAL:
                instr_s = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                           rd_i, OP_JAL};
            ID_LUI:   instr_s = {imm_i[31:12], rd_i, OP_LUI};
            ID_AUIPC: instr_s = {imm_i[31:12], rd_i, OP_AUIPC};
            default: begin
                instr_s   = 32'h0000_0000;
                illegal_s = 1'b1;
            end
        endcase
    end

    assign instr_o = instr_s;

`ifdef ENC_IMM_CHECK_EN
    logic range_err_s;

    // Flags immediates that would lose information when truncated into their field.
    always_comb begin
        range_err_s = 1'b0;
        case (id_i)
            ID_ADDI, ID_XORI, ID_ORI, ID_ANDI, ID_SLTI, ID_SLTIU,
            ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU, ID_JALR,
            ID_SB, ID_SH, ID_SW:
                range_err_s = ~fits_s12(imm_i);
            ID_SLLI, ID_SRLI, ID_SRAI:
                range_err_s = (imm_i[31:5] != 27'd0);
            ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU:
                range_err_s = ~fits_s13(imm_i) | imm_i[0];
            ID_JAL:
                range_err_s = ~fits_s21(imm_i) | imm_i[0];
            ID_LUI, ID_AUIPC:
                range_err_s = (imm_i[11:0] != 12'd0);
            default:
                range_err_s = 1'b0;
        endcase
    end

    assign err_o = illegal_s | range_err_s;
`else
    assign err_o = illegal_s;
`endif

endmodule

// File: rtl/riscv_instr_encoder.sv
// -----------------------------------------------------------------------------
// riscv_instr_encoder
// Sequential RV32I encoder / program loader. A start pulse opens a load
// session at a word-aligned base; each accepted field set is encoded and
// registered together with its byte address base + 4*index.
// Ports:
//   clock, reset        clock; asynchronous active-high reset
//   start, start_addr   open/restart a session (start_addr[1:0] ignored)
//   bus (slave)         field input handshake and encoded-word output
//   count               words accepted in the current session
//   done                session has taken DEPTH words
// Optional feature: define ENC_IMM_CHECK_EN to flag immediate range
// violations on out_err (handled in riscv_encode_fields).
// -----------------------------------------------------------------------------
module riscv_instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      start_addr,
    riscv_instr_encoder_if.slave   bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   done
);

    localparam int CW = $clog2(DEPTH) + 1;

    enc_state_e        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_err_q, out_err_d;
    logic              done_q;

    logic [31:0]       enc_instr_s;
    logic              enc_err_s;
    logic              in_ready_s;
    logic              accept_s;
    logic [ADDR_W-1:0] word_addr_s;

    riscv_encode_fields u_fields (
        .id_i    (bus.in_id),
        .rd_i    (bus.in_rd),
        .rs1_i   (bus.in_rs1),
        .rs2_i   (bus.in_rs2),
        .imm_i   (bus.in_imm),
        .instr_o (enc_instr_s),
        .err_o   (enc_err_s)
    );

    // start takes priority over an accept in the same cycle, and a stalled
    // output word blocks new input.
    assign in_ready_s  = (state_q == ST_RUN) & ~start & (~out_valid_q | bus.out_ready);
    assign accept_s    = bus.in_valid & in_ready_s;
    // Address wraps silently within ADDR_W bits.
    assign word_addr_s = base_q + ADDR_W'({count_q, 2'b00});

    // Next-state for the session FSM, word counter and output register.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        base_d      = base_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;

        if (start) begin
            state_d = ST_RUN;
            count_d = {CW{1'b0}};
            base_d  = start_addr & ~ADDR_W'(2'd3);
        end else if (accept_s) begin
            count_d = count_q + CW'(1'b1);
            if (count_q == CW'(DEPTH - 1)) begin
                state_d = ST_FULL;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = state_q;
        end

        // The output register is independent of start, so a pending word
        // survives a restart and is delivered unchanged.
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr_s;
            out_addr_d  = word_addr_s;
            out_err_d   = enc_err_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers; reset drops any pending word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= {CW{1'b0}};
            base_q      <= {ADDR_W{1'b0}};
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0000_0000;
            out_addr_q  <= {ADDR_W{1'b0}};
            out_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            base_q      <= base_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            done_q      <= (state_d == ST_FULL);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_err   = out_err_q;
    assign count         = count_q;
    assign done          = done_q;

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_riscv_instr_encoder
// Self-checking bench for riscv_instr_encoder (DEPTH = 4 so the session-full
// boundary is reachable). Directed scenarios compare against hand-encoded
// words; a randomized run compares against an arithmetic reference encoder
// and a transaction-level model of the session/handshake.
// -----------------------------------------------------------------------------
module tb_riscv_instr_encoder;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [CW-1:0]     count;
    logic              done;

    int checks = 0;
    int errors = 0;

    riscv_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    riscv_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .bus        (bus),
        .count      (count),
        .done       (done)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference encoder ----------------
    function automatic longint pack(longint f7, longint r2, longint r1, longint f3, longint rd, longint op);
        return f7 * 33554432 + r2 * 1048576 + r1 * 32768 + f3 * 4096 + rd * 128 + op;
    endfunction

    function automatic int ref_f3(int id);
        case (id)
            3, 15, 21, 26, 29: return 1;
            4, 18, 22, 27:     return 2;
            5, 19:             return 3;
            6, 12, 23, 30:     return 4;
            7, 8, 16, 17, 24, 31: return 5;
            9, 13, 32:         return 6;
            10, 14, 33:        return 7;
            default:           return 0;
        endcase
    endfunction

    // Returns {err, word}.
    function automatic logic [32:0] ref_encode(int id, int rd, int rs1, int rs2, logic [31:0] imm);
        longint u, w, jv;
        int     s, f3;
        bit     e;
        u  = {32'd0, imm};
        s  = $signed(imm);
        f3 = ref_f3(id);
        e  = 1'b0;
        w  = 0;
        if (id == 0) w = 0;
        else if (id <= 10) w = pack((id == 2 || id == 8) ? 32 : 0, rs2, rs1, f3, rd, 51);
        else if (id <= 14 || id == 18 || id == 19) w = pack((u % 4096) / 32, u % 32, rs1, f3, rd, 19);
        else if (id <= 17) w = pack((id == 17) ? 32 : 0, u % 32, rs1, f3, rd, 19);
        else if (id <= 24) w = pack((u % 4096) / 32, u % 32, rs1, f3, rd, 3);
        else if (id <= 27) w = pack((u / 32) % 128, rs2, rs1, f3, u % 32, 35);
        else if (id <= 33) w = pack(((u / 4096) % 2) * 64 + (u / 32) % 64, rs2, rs1, f3,
                                    ((u / 2) % 16) * 2 + (u / 2048) % 2, 99);
        else if (id == 34) begin
            jv = ((u / 1048576) % 2) * 524288 + ((u / 2) % 1024) * 512 + ((u / 2048) % 2) * 256 + (u / 4096) % 256;
            w  = jv * 4096 + rd * 128 + 111;
        end
        else if (id == 35) w = (u / 4096) * 4096 + rd * 128 + 55;
        else if (id == 36) w = (u / 4096) * 4096 + rd * 128 + 23;
        else if (id == 37) w = pack((u % 4096) / 32, u % 32, rs1, 0, rd, 103);
        else begin w = 0; e = 1'b1; end
`ifdef ENC_IMM_CHECK_EN
        if ((id >= 11 && id <= 14) || (id >= 18 && id <= 27) || id == 37) e = (s < -2048 || s > 2047);
        else if (id >= 15 && id <= 17) e = (u > 31);
        else if (id >= 28 && id <= 33) e = (s < -4096 || s > 4095 || (u % 2) != 0);
        else if (id == 34) e = (s < -1048576 || s > 1048575 || (u % 2) != 0);
        else if (id == 35 || id == 36) e = (u % 4096) != 0;
`else
        s = s;
`endif
        return {e, w[31:0]};
    endfunction

    // ---------------- drive helpers ----------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(int id, int rd, int rs1, int rs2, logic [31:0] imm);
        bus.in_valid = 1'b1;
        bus.in_id    = 6'(id);
        bus.in_rd    = 5'(rd);
        bus.in_rs1   = 5'(rs1);
        bus.in_rs2   = 5'(rs2);
        bus.in_imm   = imm;
    endtask

    task automatic start_session(logic [ADDR_W-1:0] a);
        start = 1'b1; start_addr = a;
        next_cycle();
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_addr = '0;
        drive(1, 1, 2, 3, 32'd0);
        bus.out_ready = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 0", bus.out_instr); end
        checks++; if (bus.out_addr !== 12'h0) begin errors++; $display("FAIL reset_out_addr got %h want 0", bus.out_addr); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", bus.out_err); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        next_cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_accept got %b want 0", bus.out_valid); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_single();
        start = 1'b1; start_addr = 12'h100;
        drive(11, 1, 0, 0, 32'd5);
        @(negedge clock);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL start_blocks_ready got %b want 0", bus.in_ready); end
        next_cycle();
        start = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL start_no_accept got %b want 0", bus.out_valid); end
        @(negedge clock);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", bus.in_ready); end
        next_cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'h00500093) begin errors++; $display("FAIL single_instr got %h want 00500093", bus.out_instr); end
        checks++; if (bus.out_addr !== 12'h100) begin errors++; $display("FAIL single_addr got %h want 100", bus.out_addr); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", bus.out_err); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        next_cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int          ids[4]  = '{1, 2, 17, 27};
        int          rds[4]  = '{3, 3, 1, 0};
        int          r1s[4]  = '{1, 1, 1, 1};
        int          r2s[4]  = '{2, 2, 0, 2};
        logic [31:0] imms[4] = '{32'd0, 32'd0, 32'd3, 32'd8};
        logic [31:0] exp[4]  = '{32'h002081B3, 32'h402081B3, 32'h4030D093, 32'h0020A423};
        bus.out_ready = 1'b1;
        start_session(12'h000);
        for (int i = 0; i < 4; i++) begin
            drive(ids[i], rds[i], r1s[i], r2s[i], imms[i]);
            @(negedge clock);
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, bus.in_ready); end
            next_cycle();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== exp[i]) begin errors++; $display("FAIL b2b_instr[%0d] got %b/%h want 1/%h", i, bus.out_valid, bus.out_instr, exp[i]); end
            checks++; if (bus.out_addr !== 12'(4 * i)) begin errors++; $display("FAIL b2b_addr[%0d] got %h want %h", i, bus.out_addr, 4 * i); end
        end
        bus.in_valid = 1'b0;
        checks++; if (done !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL b2b_full got done=%b count=%0d want 1/4", done, count); end
        next_cycle();
    endtask

    task automatic test_branch_jump_lui();
        int          ids[3]  = '{28, 34, 35};
        int          rds[3]  = '{0, 1, 5};
        int          r1s[3]  = '{1, 0, 0};
        int          r2s[3]  = '{2, 0, 0};
        logic [31:0] imms[3] = '{32'd8, 32'd16, 32'h12345000};
        logic [31:0] exp[3]  = '{32'h00208463, 32'h010000EF, 32'h123452B7};
        start_session(12'h020);
        for (int i = 0; i < 3; i++) begin
            drive(ids[i], rds[i], r1s[i], r2s[i], imms[i]);
            next_cycle();
            checks++; if (bus.out_instr !== exp[i] || bus.out_err !== 1'b0) begin errors++; $display("FAIL bjl_instr[%0d] got %h/%b want %h/0", i, bus.out_instr, bus.out_err, exp[i]); end
            checks++; if (bus.out_addr !== 12'(32 + 4 * i)) begin errors++; $display("FAIL bjl_addr[%0d] got %h want %h", i, bus.out_addr, 32 + 4 * i); end
        end
        bus.in_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [32:0] wa, wb;
        wa = ref_encode(1, 4, 5, 6, 32'd0);
        wb = ref_encode(6, 5, 6, 7, 32'd0);
        start_session(12'h200);
        bus.out_ready = 1'b0;
        drive(1, 4, 5, 6, 32'd0);
        next_cycle();
        drive(6, 5, 6, 7, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== wa[31:0] || bus.out_addr !== 12'h200) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h/%h want 1/%h/200", i, bus.out_valid, bus.out_instr, bus.out_addr, wa[31:0]); end
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL bp_count[%0d] got %0d want 1", i, count); end
            next_cycle();
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", bus.in_ready); end
        next_cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_instr !== wb[31:0] || bus.out_addr !== 12'h204 || count !== 3'd2) begin errors++; $display("FAIL bp_next got %h/%h/%0d want %h/204/2", bus.out_instr, bus.out_addr, count, wb[31:0]); end
        next_cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b want 0", bus.out_valid); end
    endtask

    task automatic test_depth();
        logic [32:0] w5;
        w5 = ref_encode(13, 9, 9, 0, 32'h55);
        start_session(12'h040);
        for (int i = 0; i < 4; i++) begin
            drive(11, i + 1, 0, 0, 32'(i));
            next_cycle();
            checks++; if (bus.out_addr !== 12'(64 + 4 * i)) begin errors++; $display("FAIL depth_addr[%0d] got %h want %h", i, bus.out_addr, 64 + 4 * i); end
        end
        drive(13, 9, 9, 0, 32'h55);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++; if (bus.in_ready !== 1'b0 || done !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL depth_full[%0d] got rdy=%b done=%b cnt=%0d want 0/1/4", i, bus.in_ready, done, count); end
            next_cycle();
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL depth_5th_taken got %b want 0", bus.out_valid); end
        start = 1'b1; start_addr = 12'h080;
        @(negedge clock);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL depth_start_ready got %b want 0", bus.in_ready); end
        next_cycle();
        start = 1'b0;
        checks++; if (done !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL depth_restart got done=%b cnt=%0d want 0/0", done, count); end
        next_cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== w5[31:0] || bus.out_addr !== 12'h080) begin errors++; $display("FAIL depth_5th got %b/%h/%h want 1/%h/080", bus.out_valid, bus.out_instr, bus.out_addr, w5[31:0]); end
        next_cycle();
    endtask

    task automatic test_start_pending();
        logic [32:0] wp, wq;
        wp = ref_encode(22, 7, 8, 0, 32'hFFFFFFFC);
        wq = ref_encode(36, 3, 0, 0, 32'hABCDE000);
        start_session(12'h300);
        bus.out_ready = 1'b0;
        drive(22, 7, 8, 0, 32'hFFFFFFFC);
        next_cycle();
        bus.in_valid = 1'b0;
        start_session(12'h107);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== wp[31:0] || bus.out_addr !== 12'h300 || count !== 3'd0) begin errors++; $display("FAIL pend_survive got %b/%h/%h/%0d want 1/%h/300/0", bus.out_valid, bus.out_instr, bus.out_addr, count, wp[31:0]); end
        bus.out_ready = 1'b1;
        drive(36, 3, 0, 0, 32'hABCDE000);
        next_cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_instr !== wq[31:0] || bus.out_addr !== 12'h104) begin errors++; $display("FAIL pend_newbase got %h/%h want %h/104", bus.out_instr, bus.out_addr, wq[31:0]); end
        next_cycle();
    endtask

    task automatic test_illegal();
        logic exp_err;
`ifdef ENC_IMM_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        start_session(12'h010);
        drive(40, 1, 2, 3, 32'h7);
        next_cycle();
        checks++; if (bus.out_instr !== 32'h0 || bus.out_err !== 1'b1 || bus.out_addr !== 12'h010) begin errors++; $display("FAIL illegal_40 got %h/%b/%h want 0/1/010", bus.out_instr, bus.out_err, bus.out_addr); end
        drive(11, 0, 0, 0, 32'd2048);
        next_cycle();
        checks++; if (bus.out_instr !== 32'h80000013 || bus.out_addr !== 12'h014) begin errors++; $display("FAIL addi2048_instr got %h/%h want 80000013/014", bus.out_instr, bus.out_addr); end
        checks++; if (bus.out_err !== exp_err) begin errors++; $display("FAIL addi2048_err got %b want %b", bus.out_err, exp_err); end
        drive(63, 0, 0, 0, 32'd0);
        next_cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_instr !== 32'h0 || bus.out_err !== 1'b1) begin errors++; $display("FAIL illegal_63 got %h/%b want 0/1", bus.out_instr, bus.out_err); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        start_session(12'h500);
        bus.out_ready = 1'b0;
        drive(9, 1, 2, 3, 32'd0);
        next_cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", bus.out_valid); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || count !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_async got %b/%h/%0d/%b want 0/0/0/0", bus.out_valid, bus.out_instr, count, done); end
        next_cycle();
        reset = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_random();
        bit          active = 1'b0, pend = 1'b0, do_start, exp_ready, take;
        int          idx = 0, base = 0, paddr = 0;
        logic [31:0] pw = 32'h0, imm;
        logic        perr = 1'b0;
        int          id, rd, rs1, rs2;
        for (int i = 0; i < 400; i++) begin
            do_start = (i == 0) || ($urandom_range(0, 24) == 0);
            start = do_start;
            if (do_start) start_addr = 12'($urandom_range(0, 4095));
            id = $urandom_range(0, 45); rd = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0: imm = 32'($urandom_range(0, 127) - 64);
                1: imm = $urandom;
                2: imm = $urandom & 32'hFFFFF000;
                default: imm = 32'(2 * ($urandom_range(0, 5000) - 2500));
            endcase
            drive(id, rd, rs1, rs2, imm);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            exp_ready = !do_start && active && idx < DEPTH && (!pend || bus.out_ready);
            checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", i, bus.in_ready, exp_ready); end
            take = bus.in_valid && exp_ready;
            if (pend && bus.out_ready) pend = 1'b0;
            if (take) begin
                {perr, pw} = ref_encode(id, rd, rs1, rs2, imm);
                paddr = (base + 4 * idx) % 4096;
                idx++;
                pend = 1'b1;
            end
            if (do_start) begin
                active = 1'b1; idx = 0; base = int'(start_addr) - int'(start_addr) % 4;
            end
            next_cycle();
            checks++; if (bus.out_valid !== pend) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.out_valid, pend); end
            if (pend) begin
                checks++; if (bus.out_instr !== pw || bus.out_err !== perr || bus.out_addr !== 12'(paddr)) begin errors++; $display("FAIL rnd_word[%0d] got %h/%b/%h want %h/%b/%h", i, bus.out_instr, bus.out_err, bus.out_addr, pw, perr, 12'(paddr)); end
            end
            checks++; if (count !== 3'(idx) || done !== (idx == DEPTH)) begin errors++; $display("FAIL rnd_count[%0d] got %0d/%b want %0d/%b", i, count, done, idx, idx == DEPTH); end
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_branch_jump_lui();
        test_backpressure();
        test_depth();
        test_start_pending();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
